// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers (x, y) from VGA sync edges, checks line/frame geometry and builds a per-frame checksum
module vga_sync_decoder #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [3:0]  VGA_R,
  input  logic [3:0]  VGA_G,
  input  logic [3:0]  VGA_B,
  output logic        pix_valid,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic [11:0] color,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [15:0] frame_sum,
  output logic [15:0] frame_count,
  output logic        locked,
  output logic        sync_err
);
  localparam logic [10:0] H_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] H_START = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
  logic        h_prev_q, h_prev_d, v_prev_q, v_prev_d;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        v_pend_q, v_pend_d, line_seen_q, line_seen_d, line_bad_q, line_bad_d;
  logic        frame_seen_q, frame_seen_d;
  logic [15:0] sum_q, sum_d;
  logic [1:0]  good_cnt_q, good_cnt_d;
  logic        pix_valid_q, pix_valid_d, frame_done_q, frame_done_d, frame_ok_q, frame_ok_d;
  logic        sync_err_q, sync_err_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [11:0] color_q, color_d;
  logic [15:0] frame_sum_q, frame_sum_d, frame_count_q, frame_count_d;
  logic        hfall, vfall, boundary, line_err, fdone, fok, serr, active;
  logic [10:0] h_new;
  logic [9:0]  v_new;
  logic [11:0] pix_color;
  assign pix_color = {VGA_R, VGA_G, VGA_B};
  assign hfall     = h_prev_q & ~hSync;
  assign vfall     = v_prev_q & ~vSync;
  // a vSync fall only marks the frame; the boundary itself lands on the next (or same) hSync fall
  assign boundary  = hfall & (v_pend_q | vfall);
  assign h_new     = hfall ? 11'd0 : (&h_cnt_q) ? h_cnt_q : h_cnt_q + 11'd1;
  assign v_new     = boundary ? 10'd0 : !hfall ? v_cnt_q : (&v_cnt_q) ? v_cnt_q : v_cnt_q + 10'd1;
  assign line_err  = hfall & line_seen_q & (h_cnt_q != H_LAST);
  assign fdone     = boundary & frame_seen_q;
  assign fok       = (v_cnt_q == V_LAST) & ~line_bad_q & ~line_err;
  assign serr      = line_err | (fdone & ~fok);
  assign active    = (h_new >= H_START) && (h_new < H_END) && (v_new >= V_START) && (v_new < V_END);
  // per-sample decode: counters, geometry checks, pixel re-emission and frame bookkeeping
  always_comb begin
    h_prev_d      = h_prev_q;
    v_prev_d      = v_prev_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    v_pend_d      = v_pend_q;
    line_seen_d   = line_seen_q;
    line_bad_d    = line_bad_q;
    frame_seen_d  = frame_seen_q;
    sum_d         = sum_q;
    good_cnt_d    = good_cnt_q;
    pix_valid_d   = 1'b0;
    frame_done_d  = 1'b0;
    sync_err_d    = 1'b0;
    frame_ok_d    = frame_ok_q;
    x_d           = x_q;
    y_d           = y_q;
    color_d       = color_q;
    frame_sum_d   = frame_sum_q;
    frame_count_d = frame_count_q;
    if (pix_en) begin
      h_prev_d      = hSync;
      v_prev_d      = vSync;
      h_cnt_d       = h_new;
      v_cnt_d       = v_new;
      v_pend_d      = boundary ? 1'b0 : (v_pend_q | vfall);
      line_seen_d   = line_seen_q | hfall;
      line_bad_d    = fdone ? 1'b0 : (line_bad_q | line_err);
      frame_seen_d  = frame_seen_q | boundary;
      sum_d         = fdone ? 16'd0 : active ? sum_q + {4'd0, pix_color} : sum_q;
      good_cnt_d    = serr ? 2'd0 : (fdone && good_cnt_q != 2'd2) ? good_cnt_q + 2'd1 : good_cnt_q;
      pix_valid_d   = active;
      frame_done_d  = fdone;
      sync_err_d    = serr;
      frame_ok_d    = fdone ? fok : frame_ok_q;
      x_d           = active ? 10'(h_new - H_START) : x_q;
      y_d           = active ? 9'(v_new - V_START) : y_q;
      color_d       = active ? pix_color : color_q;
      frame_sum_d   = fdone ? sum_q : frame_sum_q;
      frame_count_d = fdone ? frame_count_q + 16'd1 : frame_count_q;
    end
  end
  // state registers; counters reset saturated so nothing is active before the first syncs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_prev_q      <= 1'b1;
      v_prev_q      <= 1'b1;
      h_cnt_q       <= '1;
      v_cnt_q       <= '1;
      v_pend_q      <= 1'b0;
      line_seen_q   <= 1'b0;
      line_bad_q    <= 1'b0;
      frame_seen_q  <= 1'b0;
      sum_q         <= '0;
      good_cnt_q    <= '0;
      pix_valid_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      sync_err_q    <= 1'b0;
      frame_ok_q    <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      color_q       <= '0;
      frame_sum_q   <= '0;
      frame_count_q <= '0;
    end else begin
      h_prev_q      <= h_prev_d;
      v_prev_q      <= v_prev_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      v_pend_q      <= v_pend_d;
      line_seen_q   <= line_seen_d;
      line_bad_q    <= line_bad_d;
      frame_seen_q  <= frame_seen_d;
      sum_q         <= sum_d;
      good_cnt_q    <= good_cnt_d;
      pix_valid_q   <= pix_valid_d;
      frame_done_q  <= frame_done_d;
      sync_err_q    <= sync_err_d;
      frame_ok_q    <= frame_ok_d;
      x_q           <= x_d;
      y_q           <= y_d;
      color_q       <= color_d;
      frame_sum_q   <= frame_sum_d;
      frame_count_q <= frame_count_d;
    end
  end
  assign pix_valid   = pix_valid_q;
  assign x           = x_q;
  assign y           = y_q;
  assign color       = color_q;
  assign frame_done  = frame_done_q;
  assign frame_ok    = frame_ok_q;
  assign frame_sum   = frame_sum_q;
  assign frame_count = frame_count_q;
  assign locked      = (good_cnt_q == 2'd2);
  assign sync_err    = sync_err_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: scoreboard bench driving a reduced-geometry VGA stream against a frame/line-level model
module tb_vga_sync_decoder;
  localparam int HA = 10, HF = 2, HS = 4, HB = 3;
  localparam int VA = 6, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  logic        clk = 1'b0, reset = 1'b0, pix_en = 1'b0, hSync = 1'b1, vSync = 1'b1;
  logic [3:0]  vga_r = '0, vga_g = '0, vga_b = '0;
  logic        pix_valid, frame_done, frame_ok, locked, sync_err;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [11:0] color;
  logic [15:0] frame_sum, frame_count;
  typedef struct {int x; int y; int c;} pix_t;
  typedef struct {bit ok; int sum; int cnt; bit lk;} frm_t;
  pix_t pix_q[$];
  frm_t frm_q[$];
  int   err_q[$];
  int   checks = 0, fails = 0;
  bit   pend_v = 0, pend_ok = 0;
  int   pend_sum = 0, good = 0, fcount = 0;

  vga_sync_decoder #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hSync(hSync), .vSync(vSync),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .pix_valid(pix_valid), .x(x), .y(y), .color(color),
    .frame_done(frame_done), .frame_ok(frame_ok), .frame_sum(frame_sum),
    .frame_count(frame_count), .locked(locked), .sync_err(sync_err));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one pix_en sample every 4 clks; sync/colour lines wander while pix_en is low
  task automatic send(input bit hs, input bit vs, input logic [11:0] c);
    @(negedge clk);
    hSync = hs; vSync = vs; {vga_r, vga_g, vga_b} = c; pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    hSync = 1'($urandom); vSync = 1'($urandom); {vga_r, vga_g, vga_b} = 12'($urandom);
    repeat (2) @(negedge clk);
  endtask

  // the verdict of the previous complete frame is reported at the start of this one
  task automatic frame_start_event();
    frm_t f;
    if (pend_v) begin
      good   = pend_ok ? (good < 2 ? good + 1 : 2) : 0;
      fcount = (fcount + 1) % 65536;
      f.ok = pend_ok; f.sum = pend_sum; f.cnt = fcount; f.lk = (good == 2);
      frm_q.push_back(f);
      if (!pend_ok) err_q.push_back(1);
      pend_v = 0;
    end
  endtask

  // frame of nlines lines; line short_l (if >= 0) is one pixel short; pat 0 random, 1 all fff, 2 single pixel
  task automatic gen_frame(input int nlines, input int short_l, input int pat);
    int s = 0;
    frame_start_event();
    for (int l = 0; l < nlines; l++) begin
      int len;
      if (l > 0 && l - 1 == short_l) begin
        good = 0;
        err_q.push_back(1);
      end
      len = (l == short_l) ? HT - 1 : HT;
      for (int p = 0; p < len; p++) begin
        bit act;
        logic [11:0] c;
        pix_t e;
        act = (p >= HS + HB) && (p < HS + HB + HA) && (l >= VS + VB) && (l < VS + VB + VA);
        c = 12'($urandom);
        if (act && pat == 1) c = 12'hfff;
        if (act && pat == 2) c = (p == HS + HB + HA - 1 && l == VS + VB + VA - 1) ? 12'h0a5 : 12'h000;
        if (act) begin
          e.x = p - HS - HB; e.y = l - VS - VB; e.c = int'(c);
          pix_q.push_back(e);
          s = (s + int'(c)) % 65536;
        end
        send(p >= HS, l >= VS, c);
      end
    end
    pend_v = 1;
    pend_ok = (nlines == VT) && (short_l < 0);
    pend_sum = s;
  endtask

  // tail of a frame entered without a boundary: nothing is expected from it
  task automatic partial(input int l0, input int l1);
    for (int l = l0; l < l1; l++)
      for (int p = 0; p < HT; p++)
        send(p >= HS, l >= VS, 12'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_frame_sum", frame_sum, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_locked", locked, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_color", color, 0);
    pend_v = 0; good = 0; fcount = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  // monitor: every DUT pulse must match the oldest outstanding expectation of its kind
  always @(negedge clk) begin
    pix_t e;
    frm_t f;
    if (reset) begin
      if (pix_valid) begin
        if (pix_q.size() == 0) chk("pix_valid_unexpected", pix_valid, 0);
        else begin
          e = pix_q.pop_front();
          chk("pix_x", x, e.x);
          chk("pix_y", y, e.y);
          chk("pix_color", color, e.c);
        end
      end
      if (frame_done) begin
        if (frm_q.size() == 0) chk("frame_done_unexpected", frame_done, 0);
        else begin
          f = frm_q.pop_front();
          chk("frame_ok", frame_ok, f.ok);
          chk("frame_sum", frame_sum, f.sum);
          chk("frame_count", frame_count, f.cnt);
          chk("frame_locked", locked, f.lk);
        end
      end
      if (sync_err) begin
        if (err_q.size() == 0) chk("sync_err_unexpected", sync_err, 0);
        else begin
          void'(err_q.pop_front());
          chk("sync_err_locked", locked, 0);
        end
      end
    end
  end

  initial begin
    do_reset();
    gen_frame(VT, -1, 1);
    gen_frame(VT, -1, 1);
    gen_frame(VT, -1, 1);
    gen_frame(VT, -1, 2);
    gen_frame(VT, 5, 0);
    gen_frame(VT, -1, 0);
    gen_frame(VT, -1, 0);
    gen_frame(VT - 1, -1, 0);
    gen_frame(VT, -1, 0);
    gen_frame(VT, -1, 0);
    gen_frame(7, -1, 0);
    do_reset();
    partial(7, VT);
    gen_frame(VT, -1, 0);
    gen_frame(VT, -1, 0);
    gen_frame(VT, -1, 1);
    frame_start_event();
    send(1'b0, 1'b0, 12'h000);
    repeat (8) @(negedge clk);
    chk("pix_q_empty", pix_q.size(), 0);
    chk("frm_q_empty", frm_q.size(), 0);
    chk("err_q_empty", err_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
